// File: rtl/vec_mul_pipe_ctrl_if.sv
// Request/response bundle between a vector sequencer and vec_mul_pipe_ctrl.
// Defining VMUL_OVF_FLAG_EN adds the per-slot overflow flags (out_ovf).
interface vec_mul_pipe_ctrl_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [1:0]      opcode;
  logic [1:0]      precision;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] mul_out;
  logic            out_err;
  logic            busy;
`ifdef VMUL_OVF_FLAG_EN
  logic [XLEN/8-1:0] out_ovf;

  modport master (
    output in_valid, operand_a, operand_b, opcode, precision, out_ready,
    input  in_ready, out_valid, mul_out, out_err, busy, out_ovf
  );
  modport slave (
    input  in_valid, operand_a, operand_b, opcode, precision, out_ready,
    output in_ready, out_valid, mul_out, out_err, busy, out_ovf
  );
`else
  modport master (
    output in_valid, operand_a, operand_b, opcode, precision, out_ready,
    input  in_ready, out_valid, mul_out, out_err, busy
  );
  modport slave (
    input  in_valid, operand_a, operand_b, opcode, precision, out_ready,
    output in_ready, out_valid, mul_out, out_err, busy
  );
`endif
endinterface

// File: rtl/vec_mul_pipe_ctrl.sv
// Pipelined SIMD multiplier (8/16/32-bit lanes) with valid/ready back-pressure.
// Optional macro VMUL_OVF_FLAG_EN adds per-slot MUL overflow flags on out_ovf.
module vec_mul_pipe_ctrl #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 3
) (
  input  logic clk,
  input  logic rst,
  vec_mul_pipe_ctrl_if.slave bus
);

  typedef logic [2*XLEN-1:0] prod_t;

  // Full 2w-bit lane product; operands are sign- or zero-extended to 64 bits first.
  function automatic logic [63:0] laneMul(logic [31:0] a, logic [31:0] b, int w,
                                          logic sa, logic sb);
    logic [63:0] mask, ax, bx;
    mask = (64'd1 << w) - 64'd1;
    ax   = {32'd0, a} & mask;
    bx   = {32'd0, b} & mask;
    if (sa && a[w-1]) ax = ax | ~mask;
    if (sb && b[w-1]) bx = bx | ~mask;
    return ax * bx;
  endfunction

  logic  stall, accept;
  logic  signA, signB;
  prod_t prod_d;
  logic  [63:0] laneProd;

  logic        packVld;
  prod_t       packProd;
  logic [1:0]  packOp, packPrec;
  logic        stageBusy;
  logic        isMul;

  logic            outValid_q;
  logic [XLEN-1:0] mulOut_q, mulOut_d;
  logic            outErr_q, err_d;

  assign stall        = outValid_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign accept       = bus.in_valid & bus.in_ready;

  // MUL is formed signed so the overflow flag can test signed range; low half is unaffected.
  assign signA = (bus.opcode != 2'b10);
  assign signB = ~bus.opcode[1];

  always_comb begin
    prod_d   = '0;
    laneProd = '0;
    case (bus.precision)
      2'b00: for (int i = 0; i < XLEN/8; i++) begin
        laneProd = laneMul({24'd0, bus.operand_a[i*8 +: 8]}, {24'd0, bus.operand_b[i*8 +: 8]},
                           8, signA, signB);
        prod_d[i*16 +: 16] = laneProd[15:0];
      end
      2'b01: for (int i = 0; i < XLEN/16; i++) begin
        laneProd = laneMul({16'd0, bus.operand_a[i*16 +: 16]}, {16'd0, bus.operand_b[i*16 +: 16]},
                           16, signA, signB);
        prod_d[i*32 +: 32] = laneProd[31:0];
      end
      2'b10: for (int i = 0; i < XLEN/32; i++) begin
        laneProd = laneMul(bus.operand_a[i*32 +: 32], bus.operand_b[i*32 +: 32],
                           32, signA, signB);
        prod_d[i*64 +: 64] = laneProd;
      end
      default: ;
    endcase
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign packVld   = accept;
      assign packProd  = prod_d;
      assign packOp    = bus.opcode;
      assign packPrec  = bus.precision;
      assign stageBusy = 1'b0;
    end else begin : g_pipe
      logic [LATENCY-2:0] vld_q;
      prod_t              prod_q [LATENCY-1];
      logic [1:0]         op_q   [LATENCY-1];
      logic [1:0]         prec_q [LATENCY-1];

      // Products enter at stage 0; later stages give the multiplier array room to be retimed.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
        end else if (!stall) begin
          vld_q[0]  <= accept;
          prod_q[0] <= prod_d;
          op_q[0]   <= bus.opcode;
          prec_q[0] <= bus.precision;
          for (int k = 1; k < LATENCY-1; k++) begin
            vld_q[k]  <= vld_q[k-1];
            prod_q[k] <= prod_q[k-1];
            op_q[k]   <= op_q[k-1];
            prec_q[k] <= prec_q[k-1];
          end
        end
      end

      assign packVld   = vld_q[LATENCY-2];
      assign packProd  = prod_q[LATENCY-2];
      assign packOp    = op_q[LATENCY-2];
      assign packPrec  = prec_q[LATENCY-2];
      assign stageBusy = |vld_q;
    end
  endgenerate

  assign isMul = (packOp == 2'b00);

  always_comb begin
    mulOut_d = '0;
    err_d    = 1'b0;
    case (packPrec)
      2'b00: for (int i = 0; i < XLEN/8; i++)
        mulOut_d[i*8 +: 8] = isMul ? packProd[i*16 +: 8] : packProd[i*16+8 +: 8];
      2'b01: for (int i = 0; i < XLEN/16; i++)
        mulOut_d[i*16 +: 16] = isMul ? packProd[i*32 +: 16] : packProd[i*32+16 +: 16];
      2'b10: for (int i = 0; i < XLEN/32; i++)
        mulOut_d[i*32 +: 32] = isMul ? packProd[i*64 +: 32] : packProd[i*64+32 +: 32];
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      mulOut_q   <= '0;
      outErr_q   <= 1'b0;
    end else if (!stall) begin
      outValid_q <= packVld;
      if (packVld) begin
        mulOut_q <= mulOut_d;
        outErr_q <= err_d;
      end
    end
  end

`ifdef VMUL_OVF_FLAG_EN
  logic [XLEN/8-1:0] ovf_q, ovf_d;

  // Flag sits in the lowest 8-bit slot of each lane; other slots stay zero.
  always_comb begin
    ovf_d = '0;
    if (isMul) begin
      case (packPrec)
        2'b00: for (int i = 0; i < XLEN/8; i++)
          ovf_d[i] = packProd[i*16+8 +: 8] != {8{packProd[i*16+7]}};
        2'b01: for (int i = 0; i < XLEN/16; i++)
          ovf_d[i*2] = packProd[i*32+16 +: 16] != {16{packProd[i*32+15]}};
        2'b10: for (int i = 0; i < XLEN/32; i++)
          ovf_d[i*4] = packProd[i*64+32 +: 32] != {32{packProd[i*64+31]}};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ovf_q <= '0;
    else if (!stall && packVld)
      ovf_q <= ovf_d;
  end

  assign bus.out_ovf = ovf_q;
`endif

  assign bus.out_valid = outValid_q;
  assign bus.mul_out   = mulOut_q;
  assign bus.out_err   = outErr_q;
  assign bus.busy      = outValid_q | stageBusy;

endmodule

// File: tb/tb_vec_mul_pipe_ctrl.sv
// Self-checking bench for vec_mul_pipe_ctrl (XLEN=32, LATENCY=3) with an arithmetic lane model.
// Builds with or without VMUL_OVF_FLAG_EN; out_ovf is only compared when the macro is defined.
module tb_vec_mul_pipe_ctrl;
  localparam int XLEN    = 32;
  localparam int LATENCY = 3;

  typedef struct packed {
    logic        err;
    logic [3:0]  ovf;
    logic [31:0] mul;
  } result_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vec_mul_pipe_ctrl_if #(.XLEN(XLEN)) bus ();

  vec_mul_pipe_ctrl #(.XLEN(XLEN), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  result_t expQ[$];
  int checks = 0;
  int errors = 0;

  // Lane results from plain signed/unsigned integer products rather than bit-level logic.
  function automatic result_t refModel(logic [31:0] a, logic [31:0] b,
                                       logic [1:0] op, logic [1:0] prec);
    result_t r;
    int w;
    longint unsigned mask, ua, ub;
    logic signed [127:0] av, bv, p, lim;
    logic [127:0] lo, hi;
    r = '0;
    if (prec == 2'b11) begin
      r.err = 1'b1;
      return r;
    end
    w    = 8 << prec;
    mask = (64'd1 << w) - 64'd1;
    lim  = 128'sd1 <<< (w-1);
    for (int i = 0; i < 32/w; i++) begin
      ua = (64'(a) >> (i*w)) & mask;
      ub = (64'(b) >> (i*w)) & mask;
      av = 128'(ua);
      bv = 128'(ub);
      if (op != 2'b10 && ua[w-1]) av = av - 2*lim;
      if (op[1] == 1'b0 && ub[w-1]) bv = bv - 2*lim;
      p  = av * bv;
      lo = p & 128'(mask);
      hi = (p >>> w) & 128'(mask);
      r.mul = r.mul | (32'(op == 2'b00 ? lo : hi) << (i*w));
      if (op == 2'b00 && (p < -lim || p >= lim)) r.ovf[i*w/8] = 1'b1;
    end
    return r;
  endfunction

  task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, sample 1ns later, score any consume, log any accept.
  task automatic applyStimulus(bit inV, logic [31:0] a, logic [31:0] b, logic [1:0] op,
                               logic [1:0] prec, bit outR, result_t exp);
    result_t got;
    @(negedge clk);
    bus.in_valid  = inV;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.opcode    = op;
    bus.precision = prec;
    bus.out_ready = outR;
    #1;
    checkOutput("busy", 64'(bus.busy), 64'(expQ.size() != 0));
    if (expQ.size() == 0) checkOutput("idle_out_valid", 64'(bus.out_valid), 64'd0);
    if (bus.out_valid && outR && expQ.size() != 0) begin
      got = expQ.pop_front();
      checkOutput("mul_out", 64'(bus.mul_out), 64'(got.mul));
      checkOutput("out_err", 64'(bus.out_err), 64'(got.err));
`ifdef VMUL_OVF_FLAG_EN
      checkOutput("out_ovf", 64'(bus.out_ovf), 64'(got.ovf));
`endif
    end
    if (inV && bus.in_ready) expQ.push_back(exp);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, result_t'(0));
  endtask

  task automatic drain(string tag);
    for (int n = 0; n < 40 && expQ.size() != 0; n++) idle();
    checkOutput({tag, "_drain"}, 64'(expQ.size()), 64'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    #1;
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_mul_out", 64'(bus.mul_out), 64'd0);
    checkOutput("rst_out_err", 64'(bus.out_err), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef VMUL_OVF_FLAG_EN
    checkOutput("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
`endif
  endtask

  // Single request on an idle pipe: out_valid must appear exactly LATENCY samples later.
  task automatic latencyProbe(string tag, logic [31:0] a, logic [31:0] b, logic [1:0] op,
                              logic [1:0] prec, result_t exp);
    applyStimulus(1'b1, a, b, op, prec, 1'b1, exp);
    for (int c = 1; c <= LATENCY; c++) begin
      idle();
      checkOutput($sformatf("%s_lat%0d", tag, c), 64'(bus.out_valid), 64'(c == LATENCY));
    end
    drain(tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop, rprec;
    logic [31:0] sa [8];
    logic [31:0] sb [8];
    int sent;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.opcode    = '0;
    bus.precision = '0;
    bus.out_ready = 1'b1;
    doReset();

    latencyProbe("mul32", 32'h0000_1234, 32'h0000_0010, 2'b00, 2'b10,
                 result_t'{err: 1'b0, ovf: 4'h0, mul: 32'h0001_2340});
    latencyProbe("mulh8", 32'h807F_FF02, 32'h027F_FF03, 2'b01, 2'b00,
                 result_t'{err: 1'b0, ovf: 4'h0, mul: 32'hFF3F_0000});
    latencyProbe("mulhu8", 32'h807F_FF02, 32'h027F_FF03, 2'b10, 2'b00,
                 result_t'{err: 1'b0, ovf: 4'h0, mul: 32'h013F_FE00});
    latencyProbe("mulhsu16", 32'hFFFF_0002, 32'hFFFF_0003, 2'b11, 2'b01,
                 result_t'{err: 1'b0, ovf: 4'h0, mul: 32'hFFFF_0000});
    latencyProbe("reserved", 32'hDEAD_BEEF, 32'h1234_5678, 2'b01, 2'b11,
                 result_t'{err: 1'b1, ovf: 4'h0, mul: 32'h0});
    latencyProbe("after_rsv", 32'h0000_0003, 32'h0000_0005, 2'b00, 2'b10,
                 result_t'{err: 1'b0, ovf: 4'h0, mul: 32'h0000_000F});
    latencyProbe("ovf8", 32'h0000_0010, 32'h0000_0010, 2'b00, 2'b00,
                 result_t'{err: 1'b0, ovf: 4'b0001, mul: 32'h0});

    // Eight back-to-back MULs with a four-cycle consumer stall in the middle.
    for (int i = 0; i < 8; i++) begin
      sa[i] = $urandom;
      sb[i] = $urandom;
    end
    sent = 0;
    for (int step = 0; step < 40 && (sent < 8 || expQ.size() != 0); step++) begin
      rop   = 2'b00;
      rprec = 2'(step % 3);
      if (sent < 8)
        applyStimulus(1'b1, sa[sent], sb[sent], rop, rprec, !(step >= 4 && step <= 7),
                      refModel(sa[sent], sb[sent], rop, rprec));
      else
        idle();
      if (step >= 4 && step <= 7) begin
        checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("stall_out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("stall_hold", 64'(bus.mul_out), 64'(expQ[0].mul));
      end
      if (sent < 8 && bus.in_ready) sent++;
    end
    checkOutput("stream_sent", 64'(sent), 64'd8);
    checkOutput("stream_left", 64'(expQ.size()), 64'd0);
    idle();

    // Randomized traffic with random request and consumer back-pressure.
    for (int n = 0; n < 120; n++) begin
      ra    = $urandom;
      rb    = $urandom;
      rop   = 2'($urandom_range(0, 3));
      rprec = 2'($urandom_range(0, 3));
      applyStimulus(($urandom % 4) != 0, ra, rb, rop, rprec, ($urandom % 4) != 0,
                    refModel(ra, rb, rop, rprec));
    end
    drain("random");

    // Reset with three requests in flight must drop them all.
    for (int n = 0; n < 3; n++) begin
      ra = $urandom;
      rb = $urandom;
      applyStimulus(1'b1, ra, rb, 2'b00, 2'b00, 1'b1, refModel(ra, rb, 2'b00, 2'b00));
    end
    doReset();
    for (int n = 0; n < 6; n++) idle();
    latencyProbe("post_rst", 32'h0102_0304, 32'h0506_0708, 2'b00, 2'b00,
                 refModel(32'h0102_0304, 32'h0506_0708, 2'b00, 2'b00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
